scoreboard_register_file: RTL

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

---
 rtl/regfile_pkg.sv | 19 +
 rtl/pending_scoreboard.sv | 65 ++++++
 rtl/scoreboard_register_file.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and helpers for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REGISTER_COUNT = 32;
    localparam int DEFAULT_READ_PORTS     = 2;

    // Width needed to hold a population count of 0..register_count.
    function automatic int pending_count_width(input int register_count);
        return $clog2(register_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pending_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pending_scoreboard
// Description : One pending bit per register with set/clear/flush priority
//               and a registered population count of the pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_scoreboard
    import regfile_pkg::*;
#(
    parameter  int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
    parameter  int ADDRESS_SIZE   = $clog2(REGISTER_COUNT),
    localparam int COUNT_WIDTH    = pending_count_width(REGISTER_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_enable,
    input  logic [ADDRESS_SIZE-1:0]   set_address,
    input  logic                      clear_enable,
    input  logic [ADDRESS_SIZE-1:0]   clear_address,
    input  logic                      flush,
    output logic [REGISTER_COUNT-1:0] pending,
    output logic [COUNT_WIDTH-1:0]    pending_count
);

    logic [REGISTER_COUNT-1:0] pending_q;
    logic [REGISTER_COUNT-1:0] pending_next;
    logic [COUNT_WIDTH-1:0]    count_q;
    logic [COUNT_WIDTH-1:0]    count_next;

    // Next pending state: a commit clears, a new producer overrides the clear,
    // and a flush wipes everything; address 0 never holds a reservation.
    always_comb begin
        pending_next = pending_q;
        if (clear_enable && (clear_address != '0)) begin
            pending_next[clear_address] = 1'b0;
        end
        if (set_enable && (set_address != '0)) begin
            pending_next[set_address] = 1'b1;
        end
        if (flush) begin
            pending_next = '0;
        end
        count_next = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            count_next = count_next + COUNT_WIDTH'(pending_next[i]);
        end
    end

    // Pending bits and their count update together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_next;
            count_q   <= count_next;
        end
    end

    assign pending       = pending_q;
    assign pending_count = count_q;

endmodule
`default_nettype wire

// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_register_file
// Description : Multi-read-port register file with write-through bypass and a
//               per-register pending scoreboard for in-flight producers.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter  int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
    parameter  int READ_PORTS     = DEFAULT_READ_PORTS,
    parameter  int ADDRESS_SIZE   = $clog2(REGISTER_COUNT),
    localparam int COUNT_WIDTH    = pending_count_width(REGISTER_COUNT)
) (
    input  logic                             system_clock,
    input  logic                             system_reset_n,
    input  logic                             write_enable,
    input  logic [ADDRESS_SIZE-1:0]          write_address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [READ_PORTS*ADDRESS_SIZE-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [READ_PORTS-1:0]            read_pending,
    input  logic                             reserve_enable,
    input  logic [ADDRESS_SIZE-1:0]          reserve_address,
    input  logic                             flush,
    output logic [COUNT_WIDTH-1:0]           pending_count
);

    logic [DATA_WIDTH-1:0]     register_array [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] pending_bits;
    logic                      write_commit;

    // Address 0 is hardwired to zero, so a write there is simply dropped.
    assign write_commit = write_enable && (write_address != '0);

    // Register storage; entry 0 is never written and stays zero.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                register_array[r] <= '0;
            end
        end else if (write_commit) begin
            register_array[write_address] <= write_data;
        end
    end

    pending_scoreboard #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .ADDRESS_SIZE   (ADDRESS_SIZE)
    ) u_pending_scoreboard (
        .clk           (system_clock),
        .rst_n         (system_reset_n),
        .set_enable    (reserve_enable),
        .set_address   (reserve_address),
        .clear_enable  (write_enable),
        .clear_address (write_address),
        .flush         (flush),
        .pending       (pending_bits),
        .pending_count (pending_count)
    );

    // Each read port: combinational lookup with same-cycle write bypass.
    // Outputs are forced quiet while reset is held so a live writeback
    // strobe cannot leak through the bypass path.
    generate
        for (genvar p = 0; p < READ_PORTS; p++) begin : g_read_port
            logic [ADDRESS_SIZE-1:0] port_address;
            logic                    port_nonzero;
            logic                    port_bypass;
            logic [DATA_WIDTH-1:0]   port_data;
            logic                    port_pending;

            assign port_address = read_address[p*ADDRESS_SIZE +: ADDRESS_SIZE];
            assign port_nonzero = (port_address != '0);
            assign port_bypass  = write_enable && port_nonzero
                                  && (write_address == port_address);

            // Select bypassed, stored or zero data and the masked pending flag.
            always_comb begin
                port_data    = '0;
                port_pending = 1'b0;
                if (system_reset_n && port_nonzero) begin
                    port_data    = port_bypass ? write_data
                                               : register_array[port_address];
                    port_pending = pending_bits[port_address] && !port_bypass;
                end
            end

            assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = port_data;
            assign read_pending[p]                        = port_pending;
        end
    endgenerate

endmodule
`default_nettype wire
